// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch: PC, IMEM address and the IF/ID register, with
//            stall, branch flush and trap halt. Define FETCH_PERF_EN for the
//            fetch/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [0:31] RESET_PC  = 32'h0000_0000,
    parameter logic [0:31] NOP_WORD  = 32'h5400_0000,
    parameter logic [0:31] TRAP_WORD = 32'h4400_0300
) (
    input  logic        clock,
    input  logic        reset,
    output logic [0:31] imem_addr,
    input  logic [0:31] imem_data,
    input  logic        stall,
    input  logic        branch,
    input  logic [0:31] branch_target,
    output logic [0:31] pc,
    output logic [0:31] instruction_1,
    output logic [0:31] pc_plus4_1,
    output logic        valid_1,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [0:31] perf_fetch_cnt,
    output logic [0:31] perf_stall_cnt
`endif
);

    localparam logic [0:31] c_pc_step  = 32'd4;
    localparam logic [0:31] c_cnt_max  = 32'hFFFF_FFFF;

    logic [0:31] r_pc;
    logic [0:31] r_instruction;
    logic [0:31] r_pc_plus4;
    logic        r_valid;
    logic        r_halted;

    logic [0:31] w_pc_plus4;
    logic        w_fetch;
    logic        w_stall_edge;
    logic        w_is_trap;

    assign w_pc_plus4   = r_pc + c_pc_step;
    assign w_stall_edge = !r_halted && stall;
    assign w_fetch      = !r_halted && !stall && !branch;
    assign w_is_trap    = (imem_data == TRAP_WORD);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
            r_halted      <= 1'b0;
        end else if (r_halted) begin
            r_instruction <= NOP_WORD;
            r_valid       <= 1'b0;
        end else if (stall) begin
            // A branch raised during a stall is dropped; decode re-issues it.
            r_pc          <= r_pc;
        end else if (branch) begin
            r_pc          <= branch_target;
            r_instruction <= NOP_WORD;
            r_valid       <= 1'b0;
        end else begin
            r_instruction <= imem_data;
            r_pc_plus4    <= w_pc_plus4;
            r_valid       <= 1'b1;
            // On a trap the PC parks on the trap address for good.
            if (w_is_trap) begin
                r_halted  <= 1'b1;
            end else begin
                r_pc      <= w_pc_plus4;
            end
        end
    end

    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign instruction_1 = r_instruction;
    assign pc_plus4_1    = r_pc_plus4;
    assign valid_1       = r_valid;
    assign halted        = r_halted;

`ifdef FETCH_PERF_EN
    logic [0:31] r_perf_fetch;
    logic [0:31] r_perf_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fetch && (r_perf_fetch != c_cnt_max)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_stall_edge && (r_perf_stall != c_cnt_max)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_fetch ^ w_stall_edge ^ c_cnt_max[0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage (directed scenarios plus a
//            randomized run against a behavioural IF-stage model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h5400_0000;
    localparam logic [31:0] TRAP = 32'h4400_0300;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [0:31] imem_addr;
    logic [0:31] imem_data;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [0:31] branch_target = '0;
    logic [0:31] pc;
    logic [0:31] instruction_1;
    logic [0:31] pc_plus4_1;
    logic        valid_1;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [0:31] perf_fetch_cnt;
    logic [0:31] perf_stall_cnt;
`endif

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch        (branch),
        .branch_target (branch_target),
        .pc            (pc),
        .instruction_1 (instruction_1),
        .pc_plus4_1    (pc_plus4_1),
        .valid_1       (valid_1),
        .halted        (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    // 1 KiB word memory, aliased over the full address space.
    logic [31:0] mem [0:255];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    assign imem_data = mem[widx(imem_addr)];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
    bit          m_valid, m_halted;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
        m_valid = 0; m_halted = 0; m_fcnt = 0; m_scnt = 0;
    endtask

    task automatic fill_mem();
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            do w = $urandom; while (w == TRAP);
            mem[i] = w;
        end
    endtask

    // One clock: drive inputs, advance the model by the stage's rules, settle.
    task automatic tick(input bit s, input bit b, input logic [31:0] t);
        logic [31:0] word;
        stall = s; branch = b; branch_target = t;
        if (m_halted) begin
            m_instr = NOP; m_valid = 0;
        end else if (s) begin
            if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        end else if (b) begin
            m_pc = t; m_instr = NOP; m_valid = 0;
        end else begin
            word    = mem[widx(m_pc)];
            m_instr = word;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1;
            if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
            if (word == TRAP) m_halted = 1;
            else              m_pc = m_pc + 32'd4;
        end
        @(posedge clock); #1;
        stall = 0; branch = 0;
    endtask

    task automatic do_reset();
        reset = 0; stall = 0; branch = 0;
        @(posedge clock); #1;
        model_reset();
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        @(posedge clock); #1;
        vectors++;
        if ({pc, instruction_1, pc_plus4_1, valid_1, halted} !== {32'h0, NOP, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset pc=%h ins=%h pc4=%h v=%b h=%b exp pc=0 ins=%h pc4=0 v=0 h=0",
                     pc, instruction_1, pc_plus4_1, valid_1, halted, NOP);
        end
        vectors++;
        if (imem_addr !== pc) begin
            miscompares++;
            $display("FAIL imem_addr got=%h exp=%h", imem_addr, pc);
        end
        model_reset();
        reset = 1;
    endtask

    task automatic test_fetch();
        fill_mem();
        mem[0] = 32'h2001_0005; mem[1] = 32'h2002_0007;
        do_reset();
        vectors++;
        if (pc !== 32'h0) begin miscompares++; $display("FAIL fetch_pc0 got=%h exp=0", pc); end
        tick(0, 0, 0);
        vectors++;
        if ({pc, instruction_1, pc_plus4_1, valid_1} !== {32'h4, 32'h2001_0005, 32'h4, 1'b1}) begin
            miscompares++;
            $display("FAIL fetch1 pc=%h ins=%h pc4=%h v=%b exp 4/20010005/4/1", pc, instruction_1, pc_plus4_1, valid_1);
        end
        tick(0, 0, 0);
        vectors++;
        if ({pc, instruction_1, pc_plus4_1, valid_1} !== {32'h8, 32'h2002_0007, 32'h8, 1'b1}) begin
            miscompares++;
            $display("FAIL fetch2 pc=%h ins=%h pc4=%h v=%b exp 8/20020007/8/1", pc, instruction_1, pc_plus4_1, valid_1);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 0);
            vectors++;
            if ({pc, instruction_1, pc_plus4_1, valid_1} !== {32'h8, 32'h2002_0007, 32'h8, 1'b1}) begin
                miscompares++;
                $display("FAIL stall%0d pc=%h ins=%h pc4=%h v=%b exp 8/20020007/8/1", i, pc, instruction_1, pc_plus4_1, valid_1);
            end
        end
`ifdef FETCH_PERF_EN
        vectors++;
        if (perf_stall_cnt !== 32'd2) begin miscompares++; $display("FAIL perf_stall got=%0d exp=2", perf_stall_cnt); end
        vectors++;
        if (perf_fetch_cnt !== 32'd2) begin miscompares++; $display("FAIL perf_fetch got=%0d exp=2", perf_fetch_cnt); end
`endif
        tick(0, 0, 0);
        vectors++;
        if ({pc, instruction_1, valid_1} !== {32'hC, mem[2], 1'b1}) begin
            miscompares++;
            $display("FAIL stall_resume pc=%h ins=%h v=%b exp C/%h/1", pc, instruction_1, valid_1, mem[2]);
        end
    endtask

    task automatic test_branch();
        tick(0, 0, 0);
        tick(0, 1, 32'h40);
        vectors++;
        if ({pc, instruction_1, valid_1} !== {32'h40, NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL branch pc=%h ins=%h v=%b exp 40/%h/0", pc, instruction_1, valid_1, NOP);
        end
        tick(0, 0, 0);
        vectors++;
        if ({pc, instruction_1, valid_1} !== {32'h44, mem[16], 1'b1}) begin
            miscompares++;
            $display("FAIL branch_fetch pc=%h ins=%h v=%b exp 44/%h/1", pc, instruction_1, valid_1, mem[16]);
        end
    endtask

    task automatic test_stall_branch();
        tick(0, 1, 32'h1C);
        tick(0, 0, 0);
        tick(1, 1, 32'h80);
        vectors++;
        if ({pc, instruction_1, pc_plus4_1, valid_1} !== {32'h20, mem[7], 32'h20, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_branch pc=%h ins=%h pc4=%h v=%b exp 20/%h/20/1", pc, instruction_1, pc_plus4_1, valid_1, mem[7]);
        end
        tick(0, 1, 32'h80);
        vectors++;
        if ({pc, valid_1} !== {32'h80, 1'b0}) begin
            miscompares++;
            $display("FAIL branch_reissue pc=%h v=%b exp 80/0", pc, valid_1);
        end
    endtask

    task automatic test_trap();
        mem[3] = TRAP;
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        tick(0, 0, 0);
        vectors++;
        if ({pc, instruction_1, valid_1, halted} !== {32'hC, TRAP, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL trap pc=%h ins=%h v=%b h=%b exp C/%h/1/1", pc, instruction_1, valid_1, halted, TRAP);
        end
        for (int i = 0; i < 4; i++) begin
            tick(i[0], 1'b1, 32'h200);
            vectors++;
            if ({pc, instruction_1, valid_1, halted} !== {32'hC, NOP, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL halted%0d pc=%h ins=%h v=%b h=%b exp C/%h/0/1", i, pc, instruction_1, valid_1, halted, NOP);
            end
        end
`ifdef FETCH_PERF_EN
        vectors++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== {32'd4, 32'd0}) begin
            miscompares++;
            $display("FAIL perf_halt fetch=%0d stall=%0d exp 4/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_trap_squash();
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        tick(0, 1, 32'h100);
        vectors++;
        if ({pc, instruction_1, valid_1, halted} !== {32'h100, NOP, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL trap_squash pc=%h ins=%h v=%b h=%b exp 100/%h/0/0", pc, instruction_1, valid_1, halted, NOP);
        end
        tick(0, 0, 0);
        vectors++;
        if ({instruction_1, valid_1, halted} !== {mem[64], 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL trap_squash_next ins=%h v=%b h=%b exp %h/1/0", instruction_1, valid_1, halted, mem[64]);
        end
        fill_mem();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 12; i++) tick(0, 0, 0);
        vectors++;
        if (pc !== 32'h30) begin miscompares++; $display("FAIL pre_async pc=%h exp=30", pc); end
        #3 reset = 0;
        #1;
        vectors++;
        if ({pc, instruction_1, valid_1, halted} !== {32'h0, NOP, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset pc=%h ins=%h v=%b h=%b exp 0/%h/0/0", pc, instruction_1, valid_1, halted, NOP);
        end
        @(posedge clock); #1;
        model_reset();
        reset = 1;
    endtask

    task automatic test_wrap();
        do_reset();
        tick(0, 1, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        vectors++;
        if ({pc, instruction_1, pc_plus4_1, valid_1} !== {32'h0, mem[255], 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap pc=%h ins=%h pc4=%h v=%b exp 0/%h/0/1", pc, instruction_1, pc_plus4_1, valid_1, mem[255]);
        end
    endtask

    task automatic test_random();
        int halt_cycles;
        fill_mem();
        mem[$urandom_range(20, 120)] = TRAP;
        mem[$urandom_range(121, 255)] = TRAP;
        do_reset();
        halt_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom & 32'h3FF);
            vectors++;
            if ((pc !== m_pc) || (imem_addr !== m_pc) || (instruction_1 !== m_instr) ||
                (valid_1 !== m_valid) || (halted !== m_halted) || (m_valid && (pc_plus4_1 !== m_pc4))) begin
                miscompares++;
                $display("FAIL random%0d pc=%h ins=%h pc4=%h v=%b h=%b exp %h/%h/%h/%b/%b",
                         i, pc, instruction_1, pc_plus4_1, valid_1, halted, m_pc, m_instr, m_pc4, m_valid, m_halted);
            end
`ifdef FETCH_PERF_EN
            vectors++;
            if ({perf_fetch_cnt, perf_stall_cnt} !== {m_fcnt, m_scnt}) begin
                miscompares++;
                $display("FAIL random_perf%0d fetch=%0d stall=%0d exp %0d/%0d", i, perf_fetch_cnt, perf_stall_cnt, m_fcnt, m_scnt);
            end
`endif
            if (m_halted) halt_cycles++;
            if (halt_cycles > 3) begin
                do_reset();
                halt_cycles = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_mem();
        model_reset();
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_stall_branch();
        test_trap();
        test_trap_squash();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 32-bit pipeline.
- Holds the PC and drives the IMEM address. Captures the fetched word into the IF/ID pipeline register that feeds decode.
- Handles stall, branch redirect/flush and trap-halt.
- Sits directly upstream of the decode stage; decode supplies stall and branch requests.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_WORD, 32'h54000000, bubble injected into IF/ID on flush/halt.
- TRAP_WORD, 32'h44000300, end-of-program trap encoding.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  [0:31]  byte address to IMEM; equals pc
- imem_data  in  [0:31]  IMEM read data; combinational, same cycle as imem_addr
- stall  in  1  from decode hazard unit: hold PC and IF/ID
- branch  in  1  from decode: taken branch/jump resolved this cycle
- branch_target  in  [0:31]  redirect address, valid when branch=1
- pc  out  [0:31]  current fetch PC
- instruction_1  out  [0:31]  IF/ID instruction to decode
- pc_plus4_1  out  [0:31]  IF/ID PC+4 (link value)
- valid_1  out  1  IF/ID holds a real instruction (0 = bubble)
- halted  out  1  trap has been latched; fetch frozen

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, instruction_1=NOP_WORD, pc_plus4_1=0, valid_1=0, halted=0.
  - Release takes effect at the next rising edge; the first fetch is RESET_PC.
  - Reset mid-operation discards all state immediately.
- Fetch latency: 1 cycle. The word at pc appears on instruction_1 after the next rising edge.
- Per rising edge, evaluated in this priority order:
  1. halted=1: pc holds; instruction_1=NOP_WORD, valid_1=0; stall and branch ignored.
  2. stall=1: pc, instruction_1, pc_plus4_1 and valid_1 all hold. A simultaneous branch is ignored; decode re-asserts it after the stall clears.
  3. branch=1:
     - pc <= branch_target.
     - IF/ID <= NOP_WORD, valid_1=0. The in-flight fetched word is squashed; there is no delay slot.
     - A TRAP_WORD squashed this way does not halt.
  4. Otherwise:
     - pc <= pc+4, wrapping modulo 2^32 (32'hFFFFFFFC -> 0).
     - instruction_1 <= imem_data, pc_plus4_1 <= pc+4, valid_1=1.
- Trap handling:
  - When imem_data==TRAP_WORD is latched into IF/ID under case 4, halted becomes 1 on that same edge.
  - pc freezes at the trap address; it does not advance to trap+4.
  - The trap word itself is presented on instruction_1 for exactly one cycle, then replaced by NOP_WORD.
  - halted clears only on reset.
- branch_target low two bits are not checked; pc takes the value as given. The IMEM is byte-addressed and big-endian.
- There are no combinational paths from stall or branch to instruction_1; IF/ID outputs are registered only.
- imem_addr is a direct wire from the pc register.

Optional Feature:
- FETCH_PERF_EN: when defined, adds ports perf_fetch_cnt and perf_stall_cnt, each out [0:31].
  - perf_fetch_cnt increments on every case-4 edge.
  - perf_stall_cnt increments on every case-2 edge.
  - Both reset to 0, saturate at 32'hFFFFFFFF, and freeze while halted.
- When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, IMEM words 0x20010005, 0x20020007 at addresses 0 and 4:
  - pc sequence 0, 4, 8.
  - instruction_1=0x20010005 then 0x20020007; pc_plus4_1=4 then 8; valid_1=1.
- stall=1 for 2 cycles with pc=8:
  - pc stays 8 and instruction_1 holds for both cycles.
  - Fetch resumes at 8 after stall drops.
  - With FETCH_PERF_EN, perf_stall_cnt=2.
- branch=1, branch_target=0x40 at pc=0x10:
  - Next cycle pc=0x40, instruction_1=0x54000000, valid_1=0.
  - Following cycle instruction_1=mem[0x40].
- stall=1 and branch=1 together (target 0x80) at pc=0x20:
  - pc stays 0x20 and IF/ID holds.
  - After stall drops, branch re-asserted alone -> pc=0x80.
- TRAP_WORD at 0x0C:
  - instruction_1=0x44000300 for one cycle and halted=1 on the same edge.
  - pc frozen at 0x0C; then instruction_1=0x54000000, valid_1=0 indefinitely; branch has no effect.
- Assert reset=0 mid-run at pc=0x30 (asynchronous, between edges):
  - Immediately pc=0, valid_1=0, halted=0, instruction_1=0x54000000.
- Same TRAP_WORD at 0x0C but with branch=1 in its fetch cycle:
  - Trap is squashed and halted stays 0.
